// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared core constants and writeback select codes
package wb_arbiter_pkg;

    localparam int CORE_DW  = 32;
    localparam int CORE_AW  = 6;
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_ALU,
        SEL_FIFO,
        SEL_FORCE
    } sel_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - long-latency writeback FIFO holding {addr, data} entries
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DW    = CORE_DW,
    parameter int AW    = CORE_AW,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW+DW-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {push_addr, push_data};
    end

    assign {head_addr, head_data} = mem[rptr];

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter with starvation guard and busy scoreboard
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DW     = CORE_DW,
    parameter int AW     = CORE_AW,
    parameter int DEPTH  = 4,
    parameter int STARVE = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [AW-1:0]    a_addr,
    input  logic [DW-1:0]    a_data,
    input  logic             l_valid,
    output logic             l_ready,
    input  logic [AW-1:0]    l_addr,
    input  logic [DW-1:0]    l_data,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_addr,
    output logic             we,
    output logic [AW-1:0]    wa,
    output logic [DW-1:0]    wd,
    output logic [2**AW-1:0] busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(STARVE + 1);

    logic [CW-1:0]     fifo_count;
    logic [AW-1:0]     head_addr;
    logic [DW-1:0]     head_data;
    logic              fifo_empty;
    logic              forced;
    logic              a_fire;
    logic              l_fire;
    logic              pop;
    logic [WW-1:0]     wait_cnt;
    sel_e              sel;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_data;
    logic [2**AW-1:0]  busy_next;

    wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (l_fire),
        .push_addr (l_addr),
        .push_data (l_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign fifo_empty = (fifo_count == '0);
    assign forced     = !fifo_empty && (wait_cnt == WW'(STARVE));
    assign a_ready    = !forced;
    assign l_ready    = (fifo_count < CW'(DEPTH));
    assign a_fire     = a_valid && a_ready;
    assign l_fire     = l_valid && l_ready;

    always_comb begin
        sel      = SEL_IDLE;
        pop      = 1'b0;
        sel_addr = a_addr;
        sel_data = a_data;
        if (forced) begin
            sel      = SEL_FORCE;
            pop      = 1'b1;
            sel_addr = head_addr;
            sel_data = head_data;
        end else if (a_fire) begin
            sel = SEL_ALU;
        end else if (!fifo_empty) begin
            sel      = SEL_FIFO;
            pop      = 1'b1;
            sel_addr = head_addr;
            sel_data = head_data;
        end
    end

    // Issue set is applied after the pop clear so a same-edge set wins.
    always_comb begin
        busy_next = busy;
        if (pop)
            busy_next[head_addr] = 1'b0;
        if (iss_valid && (iss_addr != AW'(ZERO_REG)))
            busy_next[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
            busy     <= '0;
            we       <= 1'b0;
            wa       <= '0;
            wd       <= '0;
        end else begin
            if (fifo_empty || pop)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(STARVE))
                wait_cnt <= wait_cnt + 1'b1;

            busy <= busy_next;

            we <= (sel != SEL_IDLE) && (sel_addr != AW'(ZERO_REG));
            if (sel != SEL_IDLE) begin
                wa <= sel_addr;
                wd <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed vector bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_valid, l_valid, iss_valid;
    logic        a_ready, l_ready;
    logic [5:0]  a_addr, l_addr, iss_addr;
    logic [31:0] a_data, l_data;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [63:0] busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk       (clk),
        .rstn      (rstn),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .l_valid   (l_valid),
        .l_ready   (l_ready),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .busy      (busy)
    );

    typedef struct {
        logic        av;
        logic [5:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [5:0]  la;
        logic [31:0] ld;
        logic        iv;
        logic [5:0]  ia;
        logic        e_we;
        logic [5:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_ar;
        logic        e_lr;
        logic [63:0] e_busy;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic av, input logic [5:0] aa, input logic [31:0] ad,
                                input logic lv, input logic [5:0] la, input logic [31:0] ld,
                                input logic iv, input logic [5:0] ia,
                                input logic e_we, input logic [5:0] e_wa, input logic [31:0] e_wd,
                                input logic [63:0] e_busy);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.lv = lv; v.la = la; v.ld = ld;
        v.iv = iv; v.ia = ia;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_ar = 1'b1; v.e_lr = 1'b1;
        v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [5:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [5:0] la, input logic [31:0] ld,
                         input logic iv, input logic [5:0] ia);
        a_valid = av; a_addr = aa; a_data = ad;
        l_valid = lv; l_addr = la; l_data = ld;
        iss_valid = iv; iss_addr = ia;
    endtask

    localparam logic [63:0] B7 = 64'd1 << 7;
    localparam logic [63:0] B9 = 64'd1 << 9;

    initial begin
        tbl[0]  = mk(0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'h0,        64'd0);
        tbl[1]  = mk(1, 5, 32'h12345678, 0, 0, 0,        0, 0,  1, 5, 32'h12345678, 64'd0);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0,        0, 0,  0, 5, 32'h12345678, 64'd0);
        tbl[3]  = mk(0, 0, 0,            0, 0, 0,        1, 7,  0, 5, 32'h12345678, B7);
        tbl[4]  = mk(0, 0, 0,            1, 7, 32'hCAFE, 0, 0,  0, 5, 32'h12345678, B7);
        tbl[5]  = mk(0, 0, 0,            0, 0, 0,        0, 0,  1, 7, 32'hCAFE,     64'd0);
        tbl[6]  = mk(1, 0, 32'hDEAD,     1, 0, 32'hBEEF, 0, 0,  0, 0, 32'hDEAD,     64'd0);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'hBEEF,     64'd0);
        tbl[8]  = mk(1, 3, 32'h33,       0, 0, 0,        0, 0,  1, 3, 32'h33,       64'd0);
        tbl[9]  = mk(0, 0, 0,            0, 0, 0,        1, 9,  0, 3, 32'h33,       B9);
        tbl[10] = mk(0, 0, 0,            1, 9, 32'h99,   0, 0,  0, 3, 32'h33,       B9);
        tbl[11] = mk(0, 0, 0,            0, 0, 0,        1, 9,  1, 9, 32'h99,       B9);
        tbl[12] = mk(0, 0, 0,            0, 0, 0,        0, 0,  0, 9, 32'h99,       B9);
        tbl[13] = mk(1, 9, 32'hAA,       0, 0, 0,        0, 0,  1, 9, 32'hAA,       B9);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        #2;
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_busy", busy, 64'd0);
        tick();
        tick();
        rstn = 1'b1;
        chk("rst_a_ready", 64'(a_ready), 64'd1);
        chk("rst_l_ready", 64'(l_ready), 64'd1);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld,
                  tbl[i].iv, tbl[i].ia);
            tick();
            chk($sformatf("v%0d_we", i), 64'(we), 64'(tbl[i].e_we));
            chk($sformatf("v%0d_wa", i), 64'(wa), 64'(tbl[i].e_wa));
            chk($sformatf("v%0d_wd", i), 64'(wd), 64'(tbl[i].e_wd));
            chk($sformatf("v%0d_a_ready", i), 64'(a_ready), 64'(tbl[i].e_ar));
            chk($sformatf("v%0d_l_ready", i), 64'(l_ready), 64'(tbl[i].e_lr));
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
        end

        // Starvation: ALU held busy while four long writes fill the FIFO.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h100 + i, 1, 6'(10 + i), 32'h200 + i, 0, 0);
            tick();
            chk($sformatf("st_push%0d_wa", i), 64'(wa), 64'd1);
            chk($sformatf("st_push%0d_l_ready", i), 64'(l_ready), (i == 3) ? 64'd0 : 64'd1);
        end
        drive(1, 1, 32'h1FF, 1, 14, 32'h204, 0, 0);
        for (int k = 5; k <= 9; k++) begin
            tick();
            chk($sformatf("st_e%0d_a_ready", k), 64'(a_ready), (k == 9) ? 64'd0 : 64'd1);
            chk($sformatf("st_e%0d_l_ready", k), 64'(l_ready), 64'd0);
            chk($sformatf("st_e%0d_wa", k), 64'(wa), 64'd1);
        end
        tick();
        chk("st_force_we", 64'(we), 64'd1);
        chk("st_force_wa", 64'(wa), 64'd10);
        chk("st_force_wd", 64'(wd), 64'h200);
        chk("st_after_a_ready", 64'(a_ready), 64'd1);
        chk("st_after_l_ready", 64'(l_ready), 64'd1);
        tick();
        chk("st_push5_wa", 64'(wa), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("st_drain%0d_we", j), 64'(we), 64'd1);
            chk($sformatf("st_drain%0d_wa", j), 64'(wa), 64'(11 + j));
        end
        tick();
        chk("st_idle_we", 64'(we), 64'd0);

        // Reset with three queued entries and a pending busy bit.
        drive(1, 1, 32'h1, 1, 3, 32'h300, 1, 3);
        tick();
        drive(1, 1, 32'h1, 1, 4, 32'h400, 0, 0);
        tick();
        drive(1, 1, 32'h1, 1, 5, 32'h500, 0, 0);
        tick();
        chk("rm_busy3_set", 64'(busy[3]), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("rm_we", 64'(we), 64'd0);
        chk("rm_busy", busy, 64'd0);
        chk("rm_wa", 64'(wa), 64'd0);
        tick();
        tick();
        rstn = 1'b1;
        chk("rm_a_ready", 64'(a_ready), 64'd1);
        chk("rm_l_ready", 64'(l_ready), 64'd1);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk($sformatf("rm_post%0d_we", j), 64'(we), 64'd0);
            chk($sformatf("rm_post%0d_wa", j), 64'(wa), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
